// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_SIZE data bits LSB first, parity, STOP_BITS stop bits.
// A one-word holding buffer lets the next frame follow the current one with no idle gap.
module uart_tx #(
    parameter int CLK_FREQ   = 10000,
    parameter int BAUD_RATE  = 1000,
    parameter int DATA_SIZE  = 8,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] data_in,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_SIZE - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_SIZE < 1 || DATA_SIZE > 10 || (STOP_BITS != 1 && STOP_BITS != 2) || DIV < 2)
    begin : g_param_check
        $error("uart_tx: illegal DATA_SIZE, STOP_BITS or clock/baud ratio");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_SIZE-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [DATA_SIZE-1:0]   buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   tx_q, tx_d, busy_q, busy_d, done_q, done_d;

    logic                   accept, bit_end, frame_end, load_shift, load_from_buf;
    logic [DATA_SIZE-1:0]   load_word;
    logic [9:0]             data_in_unused;

    // Payload bits above DATA_SIZE are ignored by design.
    assign data_in_unused = data_in;

    assign ready         = ~buf_full_q;
    assign accept        = start & ~buf_full_q;
    assign bit_end       = (baud_q == BAUD_LAST);
    assign frame_end     = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
    assign load_from_buf = frame_end && buf_full_q;
    assign load_shift    = ((state_q == IDLE) && accept) || (frame_end && (buf_full_q || accept));
    assign load_word     = load_from_buf ? buf_q : data_in[DATA_SIZE-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output is given a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && bit_q == DATA_LAST) state_d = PARITY;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (frame_end) state_d = load_shift ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters reload on every bit boundary, so entering START always starts at baud 0.
    always_comb begin
        baud_d     = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
        bit_d      = '0;
        shift_d    = shift_q;
        parity_d   = parity_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        if (state_q == DATA || state_q == STOP) begin
            bit_d = bit_q;
            if (bit_end) begin
                if ((state_q == DATA && bit_q == DATA_LAST) ||
                    (state_q == STOP && bit_q == STOP_LAST)) bit_d = '0;
                else                                         bit_d = bit_q + 4'd1;
            end
        end

        if (load_shift) begin
            shift_d  = load_word;
            parity_d = (^load_word) ^ (PARITY_ODD != 0);
        end else if (state_q == DATA && bit_end) begin
            shift_d = shift_q >> 1;
        end

        if (load_from_buf) begin
            buf_full_d = 1'b0;
        end else if (accept && !load_shift) begin
            buf_d      = data_in[DATA_SIZE-1:0];
            buf_full_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values, so they line up with the state register.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
